// File: rtl/instruction_encoder_pkg.sv
// ISA opcode values, field record and the 16-bit word packing shared with the decode stage.
package instruction_encoder_pkg;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_BR    = 4'd1;
  localparam logic [3:0] OP_CMP   = 4'd2;
  localparam logic [3:0] OP_ADD   = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_MUL   = 4'd5;
  localparam logic [3:0] OP_DIV   = 4'd6;
  localparam logic [3:0] OP_LDR   = 4'd7;
  localparam logic [3:0] OP_STR   = 4'd8;
  localparam logic [3:0] OP_CONST = 4'd9;
  localparam logic [3:0] OP_RET   = 4'd15;

  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] rd;
    logic [3:0] rs;
    logic [3:0] rt;
    logic [2:0] nzp;
    logic [7:0] imm;
  } fields_t;

  function automatic logic is_legal(logic [3:0] op);
    return (op <= OP_CONST) || (op == OP_RET);
  endfunction

  // Fields an opcode does not use stay zero so the decoder never sees stale values.
  function automatic logic [15:0] encode(fields_t f);
    logic [15:0] w;
    w = '0;
    w[15:12] = f.opcode;
    case (f.opcode)
      OP_BR: begin
        w[11:9] = f.nzp;
        w[7:0]  = f.imm;
      end
      OP_CMP, OP_STR: begin
        w[7:4] = f.rs;
        w[3:0] = f.rt;
      end
      OP_ADD, OP_SUB, OP_MUL, OP_DIV: begin
        w[11:8] = f.rd;
        w[7:4]  = f.rs;
        w[3:0]  = f.rt;
      end
      OP_LDR: begin
        w[11:8] = f.rd;
        w[7:4]  = f.rs;
      end
      OP_CONST: begin
        w[11:8] = f.rd;
        w[7:0]  = f.imm;
      end
      default: w[11:0] = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/instruction_encoder_if.sv
// Loader-side field bundle, program-memory write port and session status of the encoder.
interface instruction_encoder_if #(
  parameter int ADDR_BITS = 8
);
  logic                 start;
  logic [ADDR_BITS-1:0] base_address;
  logic                 in_valid;
  logic                 in_ready;
  logic [3:0]           in_opcode;
  logic [3:0]           in_rd;
  logic [3:0]           in_rs;
  logic [3:0]           in_rt;
  logic [2:0]           in_nzp;
  logic [7:0]           in_immediate;
  logic                 mem_write_valid;
  logic                 mem_write_ready;
  logic [ADDR_BITS-1:0] mem_write_address;
  logic [15:0]          mem_write_data;
  logic [ADDR_BITS:0]   word_count;
  logic                 busy;
  logic                 done;
  logic                 error;

  modport master (
    output start, base_address, in_valid, in_opcode, in_rd, in_rs, in_rt, in_nzp,
           in_immediate, mem_write_ready,
    input  in_ready, mem_write_valid, mem_write_address, mem_write_data, word_count,
           busy, done, error
  );

  modport slave (
    input  start, base_address, in_valid, in_opcode, in_rd, in_rs, in_rt, in_nzp,
           in_immediate, mem_write_ready,
    output in_ready, mem_write_valid, mem_write_address, mem_write_data, word_count,
           busy, done, error
  );
endinterface

// File: rtl/instruction_encoder_fifo.sv
// Synchronous word buffer; zero-latency dout, push accepted when not full or when popping the same cycle.
module encoder_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       din_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign count_o = wr_ptr_q - rd_ptr_q;
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (count_o == (AW+1)'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end
endmodule

// File: rtl/instruction_encoder.sv
// Encodes accepted field bundles into ISA words and streams them to program memory for one load session.
// One cycle from accept to mem_write_valid when empty; in_ready drops while the word buffer is full.
module instruction_encoder
  import instruction_encoder_pkg::*;
#(
  parameter int ADDR_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input logic                   clk,
  input logic                   reset,
  instruction_encoder_if.slave  bus
);
  localparam int FAW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [ADDR_BITS:0]   count_q, count_d;
  logic                 error_q, error_d;

  fields_t      fields;
  logic [15:0]  word;
  logic         in_load, accept, legal, is_ret;
  logic         wr_hs, overflow, push;
  logic         fifo_full, fifo_empty;
  logic [15:0]  fifo_dout;
  logic [FAW:0] fifo_count;

  assign fields = '{opcode: bus.in_opcode, rd: bus.in_rd, rs: bus.in_rs, rt: bus.in_rt,
                    nzp: bus.in_nzp, imm: bus.in_immediate};
  assign word   = encode(fields);
  assign legal  = is_legal(bus.in_opcode);
  assign is_ret = (bus.in_opcode == OP_RET);

  assign in_load = (state_q == ST_LOAD);
  assign accept  = bus.in_valid & bus.in_ready;
  assign wr_hs   = ~fifo_empty & bus.mem_write_ready;

  // Writing the top address is fatal only if another word is still owed: queued, or anything while in LOAD.
  assign overflow = wr_hs & (&addr_q) & ((fifo_count > (FAW+1)'(1)) | in_load);
  assign push     = accept & legal & ~overflow;

  encoder_fifo #(
    .WIDTH (16),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush_i (overflow),
    .push_i  (push),
    .din_i   (word),
    .pop_i   (wr_hs),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    error_d = error_q;
    if (wr_hs) begin
      addr_d  = addr_q + 1'b1;
      count_d = count_q + 1'b1;
    end
    if (accept && !legal) error_d = 1'b1;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d = ST_LOAD;
          addr_d  = bus.base_address;
          count_d = '0;
          error_d = 1'b0;
        end
      end
      ST_LOAD: begin
        if (overflow) begin
          state_d = ST_DONE;
          error_d = 1'b1;
        end else if (accept && is_ret) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (overflow) begin
          state_d = ST_DONE;
          error_d = 1'b1;
        end else if (fifo_empty) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      count_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      error_q <= error_d;
    end
  end

  assign bus.in_ready          = in_load & ~fifo_full;
  assign bus.mem_write_valid   = ~fifo_empty;
  assign bus.mem_write_address = addr_q;
  assign bus.mem_write_data    = fifo_empty ? 16'h0000 : fifo_dout;
  assign bus.word_count        = count_q;
  assign bus.busy              = (state_q == ST_LOAD) | (state_q == ST_DRAIN);
  assign bus.done              = (state_q == ST_DONE);
  assign bus.error             = error_q;
endmodule

// File: tb/tb_instruction_encoder.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences and randomized sessions.
module tb_instruction_encoder;
  import instruction_encoder_pkg::*;

  localparam int AB = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  instruction_encoder_if #(.ADDR_BITS(AB)) bus();

  instruction_encoder #(.ADDR_BITS(AB), .FIFO_DEPTH(4)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [3:0]  rt;
    logic [2:0]  nzp;
    logic [7:0]  imm;
    logic [15:0] word;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  wr_t  got_q[$];
  wr_t  exp_q[$];
  logic [7:0] nxt_addr;
  logic rand_mode = 1'b0;
  logic ready_ctl = 1'b1;
  vec_t vecs [12];

  always @(posedge clk) begin
    #1;
    bus.mem_write_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_ctl;
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.mem_write_valid === 1'b1 && bus.mem_write_ready === 1'b1)
      got_q.push_back('{addr: bus.mem_write_address, data: bus.mem_write_data});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference packing written straight from the field layout table.
  function automatic logic [15:0] exp_word(input int op, input int rd, input int rs, input int rt,
                                           input int nzp, input int imm);
    int w;
    w = op * 4096;
    if (op == 1)                 w = w + nzp * 512 + imm;
    else if (op == 2 || op == 8) w = w + rs * 16 + rt;
    else if (op >= 3 && op <= 6) w = w + rd * 256 + rs * 16 + rt;
    else if (op == 7)            w = w + rd * 256 + rs * 16;
    else if (op == 9)            w = w + rd * 256 + imm;
    return w[15:0];
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.base_address = '0;
    bus.in_valid = 1'b0;
    bus.in_opcode = '0; bus.in_rd = '0; bus.in_rs = '0; bus.in_rt = '0;
    bus.in_nzp = '0; bus.in_immediate = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic pulse_start(input logic [7:0] base);
    @(posedge clk);
    #1 bus.start = 1'b1;
    bus.base_address = base;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic start_session(input logic [7:0] base);
    got_q.delete();
    exp_q.delete();
    nxt_addr = base;
    pulse_start(base);
  endtask

  task automatic send(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs,
                      input logic [3:0] rt, input logic [2:0] nzp, input logic [7:0] imm,
                      output bit ok);
    bus.in_opcode = op; bus.in_rd = rd; bus.in_rs = rs; bus.in_rt = rt;
    bus.in_nzp = nzp; bus.in_immediate = imm;
    bus.in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic send_push(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs,
                           input logic [3:0] rt, input logic [2:0] nzp, input logic [7:0] imm,
                           input logic [15:0] word);
    bit ok;
    send(op, rd, rs, rt, nzp, imm, ok);
    check("accept", 32'(ok), 32'd1);
    exp_q.push_back('{addr: nxt_addr, data: word});
    nxt_addr = nxt_addr + 8'd1;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_reached", 32'(seen), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic compare_writes(input string tag);
    int n;
    check($sformatf("%s_nwrites", tag), 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_addr[%0d]", tag, i), 32'(got_q[i].addr), 32'(exp_q[i].addr));
      check($sformatf("%s_data[%0d]", tag, i), 32'(got_q[i].data), 32'(exp_q[i].data));
    end
  endtask

  initial begin
    bit ok;
    logic [3:0] rop, rrd, rrs, rrt;
    logic [2:0] rnzp;
    logic [7:0] rimm, rbase;
    int n;
    logic exp_err;

    vecs[0]  = '{4'd3, 4'd1, 4'd2, 4'd3, 3'd0, 8'h00, 16'h3123};
    vecs[1]  = '{4'd9, 4'd5, 4'd0, 4'd0, 3'd0, 8'hAB, 16'h95AB};
    vecs[2]  = '{4'd1, 4'd0, 4'd0, 4'd0, 3'b010, 8'h07, 16'h1407};
    vecs[3]  = '{4'd7, 4'd2, 4'd4, 4'd9, 3'd0, 8'h00, 16'h7240};
    vecs[4]  = '{4'd8, 4'd7, 4'd1, 4'd3, 3'd0, 8'h00, 16'h8013};
    vecs[5]  = '{4'd2, 4'hF, 4'hA, 4'd5, 3'd7, 8'hFF, 16'h20A5};
    vecs[6]  = '{4'd0, 4'hF, 4'hF, 4'hF, 3'd7, 8'hFF, 16'h0000};
    vecs[7]  = '{4'd4, 4'hA, 4'hB, 4'hC, 3'd5, 8'h11, 16'h4ABC};
    vecs[8]  = '{4'd5, 4'd1, 4'd0, 4'hF, 3'd0, 8'h00, 16'h510F};
    vecs[9]  = '{4'd6, 4'hE, 4'hD, 4'd0, 3'd2, 8'h22, 16'h6ED0};
    vecs[10] = '{4'd1, 4'hF, 4'hF, 4'hF, 3'd7, 8'hFF, 16'h1EFF};
    vecs[11] = '{4'd9, 4'd0, 4'hF, 4'hF, 3'd7, 8'h3C, 16'h903C};

    do_reset();
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_wr_valid", 32'(bus.mem_write_valid), 32'd0);
    check("rst_wr_addr", 32'(bus.mem_write_address), 32'd0);
    check("rst_wr_data", 32'(bus.mem_write_data), 32'd0);
    check("rst_word_count", 32'(bus.word_count), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_error", 32'(bus.error), 32'd0);

    // Vector table in one session; a second start while loading must be ignored.
    start_session(8'h10);
    pulse_start(8'h99);
    for (int i = 0; i < 12; i++)
      send_push(vecs[i].op, vecs[i].rd, vecs[i].rs, vecs[i].rt, vecs[i].nzp, vecs[i].imm,
                vecs[i].word);
    send_push(OP_RET, 4'd3, 4'd3, 4'd3, 3'd3, 8'h33, 16'hF000);
    wait_done();
    compare_writes("table");
    check("table_word_count", 32'(bus.word_count), 32'd13);
    check("table_busy", 32'(bus.busy), 32'd0);
    check("table_error", 32'(bus.error), 32'd0);

    // Memory stalls: four words fill the buffer, loader is then held off.
    ready_ctl = 1'b0;
    repeat (2) @(posedge clk);
    start_session(8'h40);
    for (int i = 0; i < 4; i++)
      send_push(OP_ADD, 4'(i), 4'(i + 1), 4'(i + 2), 3'd0, 8'd0,
                exp_word(3, i, i + 1, i + 2, 0, 0));
    @(negedge clk);
    check("bp_in_ready_full", 32'(bus.in_ready), 32'd0);
    check("bp_valid", 32'(bus.mem_write_valid), 32'd1);
    check("bp_addr", 32'(bus.mem_write_address), 32'h40);
    check("bp_data", 32'(bus.mem_write_data), 32'(exp_q[0].data));
    repeat (6) @(negedge clk);
    check("bp_data_held", 32'(bus.mem_write_data), 32'(exp_q[0].data));
    check("bp_in_ready_held", 32'(bus.in_ready), 32'd0);
    ready_ctl = 1'b1;
    @(posedge clk);
    #1;
    send_push(OP_CONST, 4'd9, 4'd0, 4'd0, 3'd0, 8'h5A, exp_word(9, 9, 0, 0, 0, 'h5A));
    send_push(OP_BR, 4'd0, 4'd0, 4'd0, 3'd4, 8'h12, exp_word(1, 0, 0, 0, 4, 'h12));
    send_push(OP_RET, 4'd0, 4'd0, 4'd0, 3'd0, 8'd0, 16'hF000);
    wait_done();
    compare_writes("bp");
    check("bp_word_count", 32'(bus.word_count), 32'd7);

    // Illegal opcode is swallowed and flags error until the next start.
    start_session(8'h20);
    send(4'b1011, 4'd1, 4'd1, 4'd1, 3'd1, 8'd1, ok);
    check("ill_accept", 32'(ok), 32'd1);
    @(negedge clk);
    check("ill_error", 32'(bus.error), 32'd1);
    check("ill_no_write", 32'(bus.mem_write_valid), 32'd0);
    check("ill_busy", 32'(bus.busy), 32'd1);
    @(posedge clk);
    #1;
    send_push(OP_RET, 4'd0, 4'd0, 4'd0, 3'd0, 8'd0, 16'hF000);
    wait_done();
    compare_writes("ill");
    check("ill_error_sticky", 32'(bus.error), 32'd1);
    start_session(8'h30);
    @(negedge clk);
    check("ill_error_cleared", 32'(bus.error), 32'd0);
    @(posedge clk);
    #1;
    send_push(OP_RET, 4'd0, 4'd0, 4'd0, 3'd0, 8'd0, 16'hF000);
    wait_done();

    // Address overflow: the top-address write with more owed ends the session.
    start_session(8'hFE);
    send_push(OP_ADD, 4'd1, 4'd1, 4'd1, 3'd0, 8'd0, 16'h3111);
    send_push(OP_SUB, 4'd2, 4'd2, 4'd2, 3'd0, 8'd0, 16'h4222);
    wait_done();
    compare_writes("ovf");
    check("ovf_error", 32'(bus.error), 32'd1);
    check("ovf_word_count", 32'(bus.word_count), 32'd2);
    check("ovf_valid", 32'(bus.mem_write_valid), 32'd0);
    check("ovf_addr_wrap", 32'(bus.mem_write_address), 32'd0);

    // Final word landing on the top address is legal.
    start_session(8'hFF);
    send_push(OP_RET, 4'd0, 4'd0, 4'd0, 3'd0, 8'd0, 16'hF000);
    wait_done();
    compare_writes("top");
    check("top_error", 32'(bus.error), 32'd0);
    check("top_word_count", 32'(bus.word_count), 32'd1);

    // Reset while draining with three words queued.
    start_session(8'h50);
    send_push(OP_ADD, 4'd1, 4'd2, 4'd3, 3'd0, 8'd0, 16'h3123);
    send_push(OP_SUB, 4'd1, 4'd2, 4'd3, 3'd0, 8'd0, 16'h4123);
    repeat (3) @(posedge clk);
    ready_ctl = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    send(OP_MUL, 4'd1, 4'd1, 4'd1, 3'd0, 8'd0, ok);
    send(OP_DIV, 4'd1, 4'd1, 4'd1, 3'd0, 8'd0, ok);
    send(OP_RET, 4'd0, 4'd0, 4'd0, 3'd0, 8'd0, ok);
    @(negedge clk);
    check("drn_busy", 32'(bus.busy), 32'd1);
    check("drn_word_count", 32'(bus.word_count), 32'd2);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("drn_rst_valid", 32'(bus.mem_write_valid), 32'd0);
    check("drn_rst_busy", 32'(bus.busy), 32'd0);
    check("drn_rst_done", 32'(bus.done), 32'd0);
    check("drn_rst_word_count", 32'(bus.word_count), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    ready_ctl = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Randomized sessions with random memory backpressure and occasional illegal opcodes.
    for (int s = 0; s < 8; s++) begin
      rbase = 8'($urandom_range(0, 'hC0));
      n = $urandom_range(1, 30);
      exp_err = 1'b0;
      rand_mode = 1'b1;
      start_session(rbase);
      for (int k = 0; k < n; k++) begin
        rop  = 4'($urandom_range(0, 14));
        rrd  = 4'($urandom_range(0, 15));
        rrs  = 4'($urandom_range(0, 15));
        rrt  = 4'($urandom_range(0, 15));
        rnzp = 3'($urandom_range(0, 7));
        rimm = 8'($urandom_range(0, 255));
        if (rop >= 4'd10) begin
          send(rop, rrd, rrs, rrt, rnzp, rimm, ok);
          check("rnd_ill_accept", 32'(ok), 32'd1);
          exp_err = 1'b1;
        end else begin
          send_push(rop, rrd, rrs, rrt, rnzp, rimm, exp_word(rop, rrd, rrs, rrt, rnzp, rimm));
        end
      end
      send_push(OP_RET, 4'($urandom_range(0, 15)), 4'd0, 4'd0, 3'd0, 8'd0, 16'hF000);
      wait_done();
      rand_mode = 1'b0;
      compare_writes($sformatf("rnd%0d", s));
      check($sformatf("rnd%0d_word_count", s), 32'(bus.word_count), 32'(exp_q.size()));
      check($sformatf("rnd%0d_error", s), 32'(bus.error), 32'(exp_err));
      repeat (2) @(posedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
